// File: rtl/corner_pkg.sv
// Shared widths, FSM states, corner indices and the coordinate smoothing helper
// used by the marker-corner tracker.
package corner_pkg;

    localparam int unsigned COORD_W  = 11;
    localparam int unsigned KEY_W    = 12;
    localparam int unsigned NCORNER  = 4;

    localparam int unsigned TL = 0;
    localparam int unsigned TR = 1;
    localparam int unsigned BL = 2;
    localparam int unsigned BR = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } corner_t;

    // cur + ((cand - cur) >>> shift), clamped to the unsigned coordinate range
    function automatic logic [COORD_W-1:0] smooth_coord(
        input logic [COORD_W-1:0] cur,
        input logic [COORD_W-1:0] cand,
        input int unsigned        shift
    );
        logic signed [KEY_W-1:0] diff;
        logic signed [KEY_W-1:0] step;
        logic signed [KEY_W:0]   sum;
        diff = $signed({1'b0, cand}) - $signed({1'b0, cur});
        step = diff >>> shift;
        sum  = $signed({2'b00, cur}) + $signed({step[KEY_W-1], step});
        if (sum[KEY_W]) begin
            return '0;
        end else if (sum[KEY_W-1]) begin
            return '1;
        end
        return sum[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/extreme_tracker.sv
// Tracks the running min or max of a key over one frame, keeping the x/y of the
// pixel that produced it. Strict compare: the earliest pixel wins ties.
module extreme_tracker
    import corner_pkg::*;
#(
    parameter bit p_is_max    = 1'b0,
    parameter bit p_is_signed = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               sample_en_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [KEY_W-1:0]   best_key_o,
    output logic [COORD_W-1:0] best_x_o,
    output logic [COORD_W-1:0] best_y_o
);

    logic               have_q, have_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               better_c;

    always_comb begin
        better_c = 1'b0;
        if (p_is_signed) begin
            if (p_is_max) better_c = $signed(key_i) > $signed(key_q);
            else          better_c = $signed(key_i) < $signed(key_q);
        end else begin
            if (p_is_max) better_c = key_i > key_q;
            else          better_c = key_i < key_q;
        end
    end

    // First qualifying pixel of a frame always loads
    always_comb begin
        have_d = have_q;
        key_d  = key_q;
        x_d    = x_q;
        y_d    = y_q;
        if (clear_i) begin
            have_d = 1'b0;
        end else if (sample_en_i && (!have_q || better_c)) begin
            have_d = 1'b1;
            key_d  = key_i;
            x_d    = x_i;
            y_d    = y_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            have_q <= 1'b0;
            key_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            have_q <= have_d;
            key_q  <= key_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign best_key_o = key_q;
    assign best_x_o   = x_q;
    assign best_y_o   = y_q;

endmodule

// File: rtl/corner_tracker.sv
// Finds the four extreme marker pixels of each frame and commits them as
// smoothed, held corner coordinates with a validity flag and update pulse.
module corner_tracker
    import corner_pkg::*;
#(
    parameter int unsigned p_frame_width  = 640,
    parameter int unsigned p_frame_height = 480,
    parameter int unsigned p_min_count    = 64,
    parameter int unsigned p_lost_frames  = 8,
    parameter int unsigned p_smooth_shift = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] VGA_X,
    input  logic [COORD_W-1:0] VGA_Y,
    input  logic               marker,
    output logic [COORD_W-1:0] top_left_x,
    output logic [COORD_W-1:0] top_left_y,
    output logic [COORD_W-1:0] top_right_x,
    output logic [COORD_W-1:0] top_right_y,
    output logic [COORD_W-1:0] bot_left_x,
    output logic [COORD_W-1:0] bot_left_y,
    output logic [COORD_W-1:0] bot_right_x,
    output logic [COORD_W-1:0] bot_right_y,
    output logic               corners_valid,
    output logic               corners_update
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LOST_W = 8;
    localparam logic [COORD_W-1:0] FRAME_W  = COORD_W'(p_frame_width);
    localparam logic [COORD_W-1:0] FRAME_H  = COORD_W'(p_frame_height);
    localparam logic [CNT_W-1:0]   MIN_CNT  = CNT_W'(p_min_count);
    localparam logic [LOST_W-1:0]  LOST_MAX = LOST_W'(p_lost_frames);

    state_e             state_q, state_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LOST_W-1:0]  lost_q, lost_d;
    logic               valid_q, valid_d;
    logic               update_q, update_d;
    corner_t            out_q [NCORNER];
    corner_t            out_d [NCORNER];

    logic               clear_c;
    logic               commit_c;
    logic               sample_c;
    logic               good_c;
    logic [KEY_W-1:0]   key_s_c;
    logic [KEY_W-1:0]   key_d_c;
    logic [COORD_W-1:0] cand_x [NCORNER];
    logic [COORD_W-1:0] cand_y [NCORNER];
    logic [KEY_W-1:0]   best_key_unused [NCORNER];

    // Frame sequencing; pend_q remembers a frame_start that coincided with frame_end
    always_comb begin
        state_d  = state_q;
        pend_d   = 1'b0;
        clear_c  = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_ACCUM;
                    clear_c = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (frame_end) begin
                    state_d = ST_COMMIT;
                    pend_d  = frame_start;
                end else if (frame_start) begin
                    clear_c = 1'b1;
                end
            end
            ST_COMMIT: begin
                commit_c = 1'b1;
                if (pend_q || frame_start) begin
                    state_d = ST_ACCUM;
                    clear_c = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign key_s_c  = {1'b0, VGA_X} + {1'b0, VGA_Y};
    assign key_d_c  = {1'b0, VGA_X} - {1'b0, VGA_Y};
    assign sample_c = (state_q == ST_ACCUM) && pixel_valid && marker && !clear_c
                      && (VGA_X < FRAME_W) && (VGA_Y < FRAME_H);

    always_comb begin
        count_d = count_q;
        if (clear_c) begin
            count_d = '0;
        end else if (sample_c && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    extreme_tracker #(.p_is_max(1'b0), .p_is_signed(1'b0)) u_tl (
        .clk(clk), .reset(reset), .clear_i(clear_c), .sample_en_i(sample_c),
        .key_i(key_s_c), .x_i(VGA_X), .y_i(VGA_Y),
        .best_key_o(best_key_unused[TL]), .best_x_o(cand_x[TL]), .best_y_o(cand_y[TL])
    );

    extreme_tracker #(.p_is_max(1'b1), .p_is_signed(1'b1)) u_tr (
        .clk(clk), .reset(reset), .clear_i(clear_c), .sample_en_i(sample_c),
        .key_i(key_d_c), .x_i(VGA_X), .y_i(VGA_Y),
        .best_key_o(best_key_unused[TR]), .best_x_o(cand_x[TR]), .best_y_o(cand_y[TR])
    );

    extreme_tracker #(.p_is_max(1'b0), .p_is_signed(1'b1)) u_bl (
        .clk(clk), .reset(reset), .clear_i(clear_c), .sample_en_i(sample_c),
        .key_i(key_d_c), .x_i(VGA_X), .y_i(VGA_Y),
        .best_key_o(best_key_unused[BL]), .best_x_o(cand_x[BL]), .best_y_o(cand_y[BL])
    );

    extreme_tracker #(.p_is_max(1'b1), .p_is_signed(1'b0)) u_br (
        .clk(clk), .reset(reset), .clear_i(clear_c), .sample_en_i(sample_c),
        .key_i(key_s_c), .x_i(VGA_X), .y_i(VGA_Y),
        .best_key_o(best_key_unused[BR]), .best_x_o(cand_x[BR]), .best_y_o(cand_y[BR])
    );

    // Commit: direct load when not yet tracking, otherwise smooth toward candidates
    always_comb begin
        good_c   = count_q >= MIN_CNT;
        valid_d  = valid_q;
        lost_d   = lost_q;
        update_d = 1'b0;
        for (int unsigned i = 0; i < NCORNER; i++) begin
            out_d[i] = out_q[i];
        end
        if (commit_c) begin
            if (good_c) begin
                for (int unsigned i = 0; i < NCORNER; i++) begin
                    if (!valid_q) begin
                        out_d[i].x = cand_x[i];
                        out_d[i].y = cand_y[i];
                    end else begin
                        out_d[i].x = smooth_coord(out_q[i].x, cand_x[i], p_smooth_shift);
                        out_d[i].y = smooth_coord(out_q[i].y, cand_y[i], p_smooth_shift);
                    end
                end
                valid_d  = 1'b1;
                lost_d   = '0;
                update_d = 1'b1;
            end else begin
                lost_d = (lost_q == '1) ? lost_q : lost_q + LOST_W'(1);
                if (lost_d >= LOST_MAX) begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            count_q  <= '0;
            lost_q   <= '0;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
            for (int unsigned i = 0; i < NCORNER; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            count_q  <= count_d;
            lost_q   <= lost_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            for (int unsigned i = 0; i < NCORNER; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign top_left_x     = out_q[TL].x;
    assign top_left_y     = out_q[TL].y;
    assign top_right_x    = out_q[TR].x;
    assign top_right_y    = out_q[TR].y;
    assign bot_left_x     = out_q[BL].x;
    assign bot_left_y     = out_q[BL].y;
    assign bot_right_x    = out_q[BR].x;
    assign bot_right_y    = out_q[BR].y;
    assign corners_valid  = valid_q;
    assign corners_update = update_q;

endmodule

// File: tb/tb_corner_tracker.sv
// Directed bench for corner_tracker: two instances share stimulus, one loading
// directly (shift 0) and one smoothing (shift 2).
module tb_corner_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        frame_end;
    logic        pixel_valid;
    logic [10:0] vga_x;
    logic [10:0] vga_y;
    logic        marker;

    logic [10:0] o0 [8];
    logic [10:0] o1 [8];
    logic        valid0, valid1, upd0, upd1;

    int checks = 0;
    int errors = 0;
    int n_upd0 = 0;
    int qx[$];
    int qy[$];

    always #5 clk = ~clk;

    corner_tracker #(.p_min_count(4), .p_lost_frames(8), .p_smooth_shift(0)) dut0 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .pixel_valid(pixel_valid), .VGA_X(vga_x), .VGA_Y(vga_y), .marker(marker),
        .top_left_x(o0[0]), .top_left_y(o0[1]), .top_right_x(o0[2]), .top_right_y(o0[3]),
        .bot_left_x(o0[4]), .bot_left_y(o0[5]), .bot_right_x(o0[6]), .bot_right_y(o0[7]),
        .corners_valid(valid0), .corners_update(upd0)
    );

    corner_tracker #(.p_min_count(4), .p_lost_frames(8), .p_smooth_shift(2)) dut1 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .pixel_valid(pixel_valid), .VGA_X(vga_x), .VGA_Y(vga_y), .marker(marker),
        .top_left_x(o1[0]), .top_left_y(o1[1]), .top_right_x(o1[2]), .top_right_y(o1[3]),
        .bot_left_x(o1[4]), .bot_left_y(o1[5]), .bot_right_x(o1[6]), .bot_right_y(o1[7]),
        .corners_valid(valid1), .corners_update(upd1)
    );

    always @(negedge clk) begin
        if (upd0) n_upd0 = n_upd0 + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given inputs applied, then return to idle inputs
    task automatic drive(input logic fs, input logic fe, input logic pv,
                         input int x, input int y, input logic m);
        frame_start = fs;
        frame_end   = fe;
        pixel_valid = pv;
        vga_x       = 11'(x);
        vga_y       = 11'(y);
        marker      = m;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pixel_valid = 1'b0;
        marker      = 1'b0;
    endtask

    // frame_start, queued marker pixels, frame_end, then the COMMIT cycle
    task automatic run_frame();
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        foreach (qx[i]) drive(1'b0, 1'b0, 1'b1, qx[i], qy[i], 1'b1);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_d0(input string tag, input int tlx, input int tly, input int trx,
                            input int try_y, input int blx, input int bly, input int brx,
                            input int bry);
        check({tag, ".tlx"}, int'(o0[0]), tlx);
        check({tag, ".tly"}, int'(o0[1]), tly);
        check({tag, ".trx"}, int'(o0[2]), trx);
        check({tag, ".try"}, int'(o0[3]), try_y);
        check({tag, ".blx"}, int'(o0[4]), blx);
        check({tag, ".bly"}, int'(o0[5]), bly);
        check({tag, ".brx"}, int'(o0[6]), brx);
        check({tag, ".bry"}, int'(o0[7]), bry);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pixel_valid = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        marker      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_d0("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst.valid", int'(valid0), 0);
        check("rst.upd", int'(upd0), 0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Basic four-marker frame, direct load
        qx = '{100, 300, 110, 290};
        qy = '{50, 60, 200, 210};
        run_frame();
        check_d0("t1", 100, 50, 300, 60, 110, 200, 290, 210);
        check("t1.valid", int'(valid0), 1);
        check("t1.upd", int'(upd0), 1);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("t1.upd_off", int'(upd0), 0);
        check("t1.n_upd", n_upd0, 1);

        // Eight under-count frames: held outputs, valid drops on the eighth
        qx = '{10, 20, 30};
        qy = '{10, 20, 30};
        for (int k = 1; k <= 8; k++) begin
            run_frame();
            check($sformatf("t2.valid%0d", k), int'(valid0), (k < 8) ? 1 : 0);
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("t2.n_upd", n_upd0, 1);
        check_d0("t2.hold", 100, 50, 300, 60, 110, 200, 290, 210);
        qx = '{200, 400, 210, 390};
        qy = '{100, 110, 300, 310};
        run_frame();
        check_d0("t2.reload", 200, 100, 400, 110, 210, 300, 390, 310);
        check("t2.valid", int'(valid0), 1);
        check("t2.d1_tlx", int'(o1[0]), 200);

        // Equal s keys: earlier pixel in raster order wins
        qx = '{20, 10, 100, 300};
        qy = '{10, 20, 100, 100};
        run_frame();
        check_d0("t3", 20, 10, 300, 100, 10, 20, 300, 100);

        // Reset mid-frame, then stray pixels and frame_end before any frame_start
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 50, 50, 1'b1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 60, 60, 1'b1);
        reset = 1'b0;
        check_d0("t5.rst", 0, 0, 0, 0, 0, 0, 0, 0);
        check("t5.valid", int'(valid0), 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 5 * i, 7 * i, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("t5.no_upd", int'(upd0), 0);
        check("t5.still_invalid", int'(valid0), 0);
        check("t5.still_zero", int'(o0[0]), 0);
        qx = '{100, 300, 110, 290};
        qy = '{50, 60, 200, 210};
        run_frame();
        check_d0("t5.load", 100, 50, 300, 60, 110, 200, 290, 210);
        check("t5.d1_tlx", int'(o1[0]), 100);
        check("t5.d1_valid", int'(valid1), 1);

        // Smoothing with shift 2: 100 -> 110 -> 100 -> 90
        qx = '{140, 300, 110, 290};
        run_frame();
        check("t4.d1_tlx_up", int'(o1[0]), 110);
        check("t4.d1_tly", int'(o1[1]), 50);
        check("t4.d1_trx", int'(o1[2]), 300);
        check("t4.d0_tlx", int'(o0[0]), 140);
        qx = '{70, 300, 110, 290};
        run_frame();
        check("t4.d1_tlx_dn1", int'(o1[0]), 100);
        qx = '{60, 300, 110, 290};
        run_frame();
        check("t4.d1_tlx_dn2", int'(o1[0]), 90);
        check("t4.d1_upd", int'(upd1), 1);

        // Last pixel, frame_end and frame_start all in one cycle
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 100, 50, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 300, 60, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 110, 200, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 290, 210, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check_d0("t6a", 100, 50, 300, 60, 110, 200, 290, 210);
        check("t6a.upd", int'(upd0), 1);
        drive(1'b0, 1'b0, 1'b1, 700, 5, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 50, 40, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 350, 45, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 60, 300, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 340, 310, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check_d0("t6b", 50, 40, 350, 45, 60, 300, 340, 310);
        check("t6b.upd", int'(upd0), 1);

        // Three in-range markers plus one off-screen: under count, held
        qx = '{700, 10, 20, 30};
        qy = '{5, 10, 20, 30};
        run_frame();
        check("t6c.upd", int'(upd0), 0);
        check("t6c.valid", int'(valid0), 1);
        check_d0("t6c.hold", 50, 40, 350, 45, 60, 300, 340, 310);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
